tex_refill_ctrl: RTL
====================

Name: tex_refill_ctrl

Overview:
- Miss/refill sequencer for the 16-set direct-mapped texture cache.
- Arbitrates the single TileLink-UH master port between texture line refills and single-word debug/config (dc) accesses.
- Issues the A-channel Get/PutFullData messages and collects D-channel beats into the line RAM.
- Commits tag/valid updates and runs cache flush, which clears all valid bits.

Parameters:
- STARVE_LIMIT, 4: number of consecutive refills granted while a dc request waits; after that, the dc request wins the next arbitration.
- LINE_BEATS_LOG2, 5: log2 of 32-bit beats per line. Default gives 32 beats, a 128-byte line, address bits [10:7] as index and [31:11] as tag.

Ports:
- core_clock_i  in  1  core clock
- core_reset_i  in  1  asynchronous, active-high reset
- miss_req_i  in  1  texture miss pending
- miss_addr_i  in  32  miss byte address
- miss_ready_o  out  1  pulse: miss accepted
- dc_req_i  in  1  dc access pending
- dc_addr_i  in  32  dc word address
- dc_data_i  in  32  dc write data
- dc_write_i  in  1  1 = PutFullData, 0 = Get
- dc_ready_o  out  1  pulse: dc accepted
- dc_data_o  out  32  dc read data
- dc_valid_o  out  1  pulse: dc response
- flush_i  in  1  flush request
- flush_done_o  out  1  pulse: flush complete
- tcache_a_opcode  out  3  TileLink A opcode
- tcache_a_param  out  3  TileLink A param
- tcache_a_size  out  4  TileLink A size
- tcache_a_address  out  32  TileLink A address
- tcache_a_mask  out  4  TileLink A mask
- tcache_a_data  out  32  TileLink A data
- tcache_a_corrupt  out  1  TileLink A corrupt
- tcache_a_valid  out  1  TileLink A valid
- tcache_a_ready  in  1  TileLink A ready
- tcache_d_opcode  in  3  TileLink D opcode
- tcache_d_denied  in  1  TileLink D denied
- tcache_d_data  in  32  TileLink D data
- tcache_d_valid  in  1  TileLink D valid
- tcache_d_ready  out  1  TileLink D ready
- fill_we_o  out  1  line-RAM word write enable
- fill_idx_o  out  4  line-RAM set index
- fill_word_o  out  LINE_BEATS_LOG2  line-RAM word index
- fill_data_o  out  32  line-RAM write data
- tag_we_o  out  1  tag/valid write enable
- tag_idx_o  out  4  tag/valid set index
- tag_o  out  21  tag value
- tag_valid_o  out  1  valid bit value
- refill_err_o  out  1  pulse: refill denied

Behaviour:
- Reset: all outputs 0; FSM in IDLE; starve counter 0. Reset mid-transaction abandons it. No tag write occurs, and the D beats still outstanding are the interconnect's responsibility.
- FSM states: IDLE, A_SEND, D_COLLECT, FLUSH.
- IDLE priority: flush_i > dc (when starve count == STARVE_LIMIT, or no miss pending) > miss > dc.
- Accept pulses miss_ready_o or dc_ready_o for 1 cycle. The request is latched and the FSM moves to A_SEND the next cycle.
- Starve counter: increments on each granted miss while dc_req_i is high; clears on dc grant; saturates at STARVE_LIMIT.
- A_SEND, refill: opcode 4 (Get), param 0, size LINE_BEATS_LOG2+2, address {miss_addr_i[31:7],7'b0}, mask 4'hF, corrupt 0.
- A_SEND, dc: opcode 0 (PutFullData) or 4 (Get), size 2, address {dc_addr_i[31:2],2'b0}, mask 4'hF, data dc_data_i.
- A handshake: tcache_a_valid stays high and fields stay stable until tcache_a_ready. The FSM then moves to D_COLLECT with tcache_a_valid low the next cycle.
- D_COLLECT: tcache_d_ready = 1. Each D beat is accepted when tcache_d_valid is high.
- Refill beat: fill_we_o=1, fill_idx_o=addr[10:7], fill_word_o=beat counter (starts at 0, +1 per beat), fill_data_o=tcache_d_data. Same cycle as the beat, combinational pass-through.
- Last refill beat (counter all ones): tag_we_o pulses the following cycle with tag_o=addr[31:11] and tag_valid_o = !denied_seen; FSM returns to IDLE.
- denied_seen is the OR of tcache_d_denied over all beats. If set, refill_err_o pulses alongside tag_we_o.
- dc response: one beat. dc_data_o is registered from tcache_d_data (0 on AccessAck, opcode 0). dc_valid_o pulses the next cycle; FSM returns to IDLE.
- FLUSH: 16 consecutive cycles of tag_we_o=1, tag_idx_o=0..15, tag_valid_o=0, tag_o=0. flush_done_o pulses the cycle after idx 15; FSM returns to IDLE.
- Requests arriving during FLUSH or a transaction are held off (no ready pulse).
- D beats arriving in IDLE or A_SEND: tcache_d_ready=0; beats are not consumed.
- Beat counter wraps only via the FSM exit; it is cleared on each A_SEND entry.

Optional Feature:
- TEX_REFILL_DENIED_RETRY_EN defined: a refill that ends with denied_seen reissues the same Get once. Beats are rewritten, refill_err_o and the tag write are suppressed for the first attempt, and the second attempt's result is final.
- Undefined: no retry; behaviour exactly as above.

Test Plan:
- Miss to 0x0000_1A80, ready high, 32 D beats with data=beat#: one Get, size 7, addr 0x1A80; fill_word 0..31, fill_idx 5; tag_we tag 0x3, valid 1.
- miss_req_i and dc_req_i held high continuously: grants go miss×4, dc, miss×4, dc…; starve counter returns to 0 after each dc grant.
- dc write 0xDEADBEEF to 0x100 with tcache_a_ready low 3 cycles: A fields stable 3 cycles; opcode 0, size 2; AccessAck gives dc_valid_o with dc_data_o=0.
- Refill with beat 7 denied: refill_err_o=1, tag_valid_o=0; with TEX_REFILL_DENIED_RETRY_EN, second clean refill gives tag_valid_o=1 and no error.
- flush_i together with miss_req_i: 16 tag clears idx 0..15, flush_done_o, then miss granted.
- core_reset_i asserted at beat 10 of a refill: all outputs 0 asynchronously; no tag_we_o; next miss starts at beat 0.

Source files
------------

// File: rtl/tex_refill_ctrl_if.sv
// TileLink-UH A/D channel bundle between the texture refill controller and the interconnect.
interface tex_refill_ctrl_if;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_valid;
  logic        d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_denied, d_data, d_valid,
    output d_ready
  );

  modport slave (
    input  a_opcode, a_param, a_size, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_denied, d_data, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tex_refill_ctrl.sv
// Texture cache miss/refill sequencer: arbitrates line refills, dc accesses and flush on one TileLink-UH port.
// Optional: define TEX_REFILL_DENIED_RETRY_EN to reissue a denied refill once before committing its result.
module tex_refill_ctrl #(
  parameter int unsigned STARVE_LIMIT    = 4,
  parameter int unsigned LINE_BEATS_LOG2 = 5
) (
  input  logic                       core_clock_i,
  input  logic                       core_reset_i,
  input  logic                       miss_req_i,
  input  logic [31:0]                miss_addr_i,
  output logic                       miss_ready_o,
  input  logic                       dc_req_i,
  input  logic [31:0]                dc_addr_i,
  input  logic [31:0]                dc_data_i,
  input  logic                       dc_write_i,
  output logic                       dc_ready_o,
  output logic [31:0]                dc_data_o,
  output logic                       dc_valid_o,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  tex_refill_ctrl_if.master          tcache,
  output logic                       fill_we_o,
  output logic [3:0]                 fill_idx_o,
  output logic [LINE_BEATS_LOG2-1:0] fill_word_o,
  output logic [31:0]                fill_data_o,
  output logic                       tag_we_o,
  output logic [3:0]                 tag_idx_o,
  output logic [25-LINE_BEATS_LOG2:0] tag_o,
  output logic                       tag_valid_o,
  output logic                       refill_err_o
);

  localparam int unsigned OFF_W  = LINE_BEATS_LOG2 + 2;
  localparam int unsigned TAG_LO = OFF_W + 4;
  localparam int unsigned SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, A_SEND, D_COLLECT, FLUSH} state_t;

  state_t                     state_q;
  logic [SC_W-1:0]            starve_q;
  logic                       is_refill_q;
  logic [LINE_BEATS_LOG2-1:0] beat_q;
  logic                       denied_q;
  logic [2:0]                 a_opcode_q;
  logic [3:0]                 a_size_q;
  logic [31:0]                a_address_q;
  logic [31:0]                a_data_q;
  logic                       a_valid_q;

  logic dc_win, d_fire, last_beat, denied_all, retry_now;

  assign dc_win     = dc_req_i && ((starve_q == SC_W'(STARVE_LIMIT)) || !miss_req_i);
  assign d_fire     = (state_q == D_COLLECT) && tcache.d_valid;
  assign last_beat  = &beat_q;
  assign denied_all = denied_q || tcache.d_denied;

  assign tcache.a_opcode  = a_opcode_q;
  assign tcache.a_param   = '0;
  assign tcache.a_size    = a_size_q;
  assign tcache.a_address = a_address_q;
  assign tcache.a_mask    = a_valid_q ? 4'hF : 4'h0;
  assign tcache.a_data    = a_data_q;
  assign tcache.a_corrupt = 1'b0;
  assign tcache.a_valid   = a_valid_q;
  assign tcache.d_ready   = (state_q == D_COLLECT);

  // Line-RAM writes follow the D beat in the same cycle; gated so idle outputs read as zero.
  always_comb begin
    fill_we_o   = d_fire && is_refill_q;
    fill_idx_o  = fill_we_o ? a_address_q[OFF_W +: 4] : '0;
    fill_word_o = fill_we_o ? beat_q : '0;
    fill_data_o = fill_we_o ? tcache.d_data : '0;
  end

`ifdef TEX_REFILL_DENIED_RETRY_EN
  logic retried_q;

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i)                           retried_q <= 1'b0;
    else if (state_q == IDLE)                   retried_q <= 1'b0;
    else if (d_fire && is_refill_q && last_beat) retried_q <= 1'b1;
  end

  assign retry_now = denied_all && !retried_q;
`else
  assign retry_now = 1'b0;
`endif

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      is_refill_q  <= 1'b0;
      beat_q       <= '0;
      denied_q     <= 1'b0;
      a_opcode_q   <= '0;
      a_size_q     <= '0;
      a_address_q  <= '0;
      a_data_q     <= '0;
      a_valid_q    <= 1'b0;
      miss_ready_o <= 1'b0;
      dc_ready_o   <= 1'b0;
      dc_data_o    <= '0;
      dc_valid_o   <= 1'b0;
      flush_done_o <= 1'b0;
      tag_we_o     <= 1'b0;
      tag_idx_o    <= '0;
      tag_o        <= '0;
      tag_valid_o  <= 1'b0;
      refill_err_o <= 1'b0;
    end else begin
      miss_ready_o <= 1'b0;
      dc_ready_o   <= 1'b0;
      dc_valid_o   <= 1'b0;
      flush_done_o <= 1'b0;
      tag_we_o     <= 1'b0;
      refill_err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            tag_we_o    <= 1'b1;
            tag_idx_o   <= '0;
            tag_o       <= '0;
            tag_valid_o <= 1'b0;
            state_q     <= FLUSH;
          end else if (dc_win || miss_req_i) begin
            is_refill_q <= !dc_win;
            beat_q      <= '0;
            denied_q    <= 1'b0;
            a_valid_q   <= 1'b1;
            state_q     <= A_SEND;
            if (dc_win) begin
              dc_ready_o  <= 1'b1;
              starve_q    <= '0;
              a_opcode_q  <= dc_write_i ? 3'd0 : 3'd4;
              a_size_q    <= 4'd2;
              a_address_q <= dc_addr_i & 32'hFFFF_FFFC;
              a_data_q    <= dc_data_i;
            end else begin
              miss_ready_o <= 1'b1;
              if (dc_req_i && (starve_q < SC_W'(STARVE_LIMIT)))
                starve_q <= starve_q + SC_W'(1);
              a_opcode_q  <= 3'd4;
              a_size_q    <= 4'(OFF_W);
              a_address_q <= miss_addr_i & LINE_MASK;
              a_data_q    <= '0;
            end
          end
        end
        A_SEND: begin
          if (tcache.a_ready) begin
            a_valid_q <= 1'b0;
            state_q   <= D_COLLECT;
          end
        end
        D_COLLECT: begin
          if (tcache.d_valid) begin
            if (is_refill_q) begin
              beat_q   <= beat_q + LINE_BEATS_LOG2'(1);
              denied_q <= denied_all;
              if (last_beat) begin
                // A retried refill reuses the latched Get fields and rewrites the whole line.
                if (retry_now) begin
                  a_valid_q <= 1'b1;
                  beat_q    <= '0;
                  denied_q  <= 1'b0;
                  state_q   <= A_SEND;
                end else begin
                  tag_we_o     <= 1'b1;
                  tag_idx_o    <= a_address_q[OFF_W +: 4];
                  tag_o        <= a_address_q[31:TAG_LO];
                  tag_valid_o  <= !denied_all;
                  refill_err_o <= denied_all;
                  state_q      <= IDLE;
                end
              end
            end else begin
              dc_data_o  <= (tcache.d_opcode == 3'd0) ? 32'd0 : tcache.d_data;
              dc_valid_o <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (tag_idx_o == 4'd15) begin
            flush_done_o <= 1'b1;
            state_q      <= IDLE;
          end else begin
            tag_we_o  <= 1'b1;
            tag_idx_o <= tag_idx_o + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
